// File: rtl/uart_word_bridge.sv
// uart_word_bridge: moves a UART byte stream into word-wide RAM regions (load)
// and reads RAM regions back out as a paced byte stream (dump).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting one clock after reset/abort before choosing a mode
//   LOAD     | collecting rx bytes into a word, writing each full word
//   RD_ISSUE | mem_addr presented for the next dump word
//   RD_WAIT  | counting down read latency, then latching mem_rdata
//   SEND     | waiting for tx_ready to hand the next byte to the transmitter
//   GAP      | ignoring tx_ready while the transmitter's Active flag rises
//   FIN      | region fully dumped, parked until mode/region changes
module uart_word_bridge #(
  parameter int WORD_BYTES    = 4,
  parameter int ADDR_W        = 8,
  parameter int N_REGIONS     = 2,
  parameter int DEPTH         = 256,
  parameter bit LITTLE_ENDIAN = 1'b1,
  parameter int RD_LATENCY    = 1,
  parameter int GAP_CLKS      = 0,
  localparam int W            = 8 * WORD_BYTES,
  localparam int RID_W        = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [RID_W-1:0]     region,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_byte,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_byte,
  output logic [RID_W-1:0]     mem_region,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [W-1:0]         mem_wdata,
  input  logic [W-1:0]         mem_rdata,
  output logic [N_REGIONS-1:0] done,
  output logic                 busy,
  output logic [7:0]           checksum
);

  localparam int GAP_W = $clog2(GAP_CLKS + 2) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [3:0] LAST_BYTE = 4'(WORD_BYTES - 1);
  localparam logic [3:0] ALL_BYTES = 4'(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE, LOAD, RD_ISSUE, RD_WAIT, SEND, GAP, FIN
  } state_t;

  state_t             state;
  logic               mode_q;
  logic [RID_W-1:0]   region_q;
  logic [ADDR_W-1:0]  ptr [N_REGIONS];
  logic [3:0]         bcnt;
  logic [W-1:0]       asm_word;
  logic [W-1:0]       sh;
  logic [1:0]         lat_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               we_r;
  logic               abort;
  logic [3:0]         lane;
  logic [W-1:0]       word_next;
  logic [7:0]         cur_byte;
  logic [W-1:0]       sh_next;

  // Any change of mode or region since the last clock cancels the operation.
  assign abort = (mode != mode_q) || (region != region_q);

  // Lane for the incoming byte and the word with that byte merged in.
  always_comb begin
    lane = LITTLE_ENDIAN ? bcnt : (LAST_BYTE - bcnt);
    word_next = asm_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (lane == 4'(i)) word_next[8*i +: 8] = rx_byte;
    end
  end

  // Next byte in wire order comes from one end of the shift register.
  always_comb begin
    cur_byte = LITTLE_ENDIAN ? sh[7:0] : sh[W-1 -: 8];
    sh_next  = LITTLE_ENDIAN ? (sh >> 8) : (sh << 8);
  end

  // Combinational strobe so tx_valid can never be seen while tx_ready is low.
  assign tx_valid = en && (state == SEND) && tx_ready && !abort;
  assign tx_byte  = tx_valid ? cur_byte : 8'h00;
  assign mem_we   = we_r && !mode;
  assign busy     = ((state == LOAD) && (bcnt != 4'd0)) ||
                    (state == RD_ISSUE) || (state == RD_WAIT) ||
                    (state == SEND) || (state == GAP);

  // Main controller: load assembly, dump sequencing, pointers and checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      region_q   <= '0;
      for (int i = 0; i < N_REGIONS; i++) ptr[i] <= '0;
      bcnt       <= '0;
      asm_word   <= '0;
      sh         <= '0;
      lat_cnt    <= '0;
      gap_cnt    <= '0;
      we_r       <= 1'b0;
      mem_region <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= '0;
      checksum   <= '0;
    end else if (!en) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      region_q   <= '0;
      for (int i = 0; i < N_REGIONS; i++) ptr[i] <= '0;
      bcnt       <= '0;
      asm_word   <= '0;
      sh         <= '0;
      lat_cnt    <= '0;
      gap_cnt    <= '0;
      we_r       <= 1'b0;
      mem_region <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= '0;
      checksum   <= '0;
    end else begin
      mode_q   <= mode;
      region_q <= region;
      we_r     <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        bcnt     <= '0;
        asm_word <= '0;
        checksum <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!mode) begin
              state <= LOAD;
            end else begin
              ptr[region]  <= '0;
              done[region] <= 1'b0;
              mem_addr     <= '0;
              mem_region   <= region;
              bcnt         <= '0;
              state        <= RD_ISSUE;
            end
          end
          LOAD: begin
            if (rx_valid && !done[region]) begin
              checksum <= checksum + rx_byte;
              if (bcnt == LAST_BYTE) begin
                we_r       <= 1'b1;
                mem_wdata  <= word_next;
                mem_addr   <= ptr[region];
                mem_region <= region;
                asm_word   <= '0;
                bcnt       <= '0;
                if (ptr[region] == LAST_ADDR) done[region] <= 1'b1;
                else ptr[region] <= ptr[region] + 1'b1;
              end else begin
                asm_word <= word_next;
                bcnt     <= bcnt + 1'b1;
              end
            end
          end
          RD_ISSUE: begin
            if (RD_LATENCY == 0) begin
              sh    <= mem_rdata;
              state <= SEND;
            end else begin
              lat_cnt <= 2'(RD_LATENCY - 1);
              state   <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (lat_cnt == 2'd0) begin
              sh    <= mem_rdata;
              state <= SEND;
            end else begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end
          SEND: begin
            if (tx_ready) begin
              checksum <= checksum + cur_byte;
              sh       <= sh_next;
              bcnt     <= bcnt + 1'b1;
              gap_cnt  <= GAP_W'(GAP_CLKS + 1);
              state    <= GAP;
            end
          end
          GAP: begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - 1'b1;
            end else if (bcnt == ALL_BYTES) begin
              if (ptr[region] == LAST_ADDR) begin
                done[region] <= 1'b1;
                state        <= FIN;
              end else begin
                ptr[region] <= ptr[region] + 1'b1;
                mem_addr    <= ptr[region] + 1'b1;
                bcnt        <= '0;
                state       <= RD_ISSUE;
              end
            end else begin
              state <= SEND;
            end
          end
          FIN: state <= FIN;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_word_bridge.sv
// Bench for uart_word_bridge: three instances (LE load, BE load, LE dump)
// share stimulus and are selected by their own en; a negedge monitor
// scores every mem_we and tx_valid against queued expectations.
module tb_uart_word_bridge;

  typedef struct {
    logic [0:0]  region;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk, rst_n, mode, rx_valid;
  logic [0:0] region;
  logic [7:0] rx_byte;
  logic tx_ready;
  logic en_a, en_b, en_c;

  logic tx_valid_a, tx_valid_b, tx_valid_c;
  logic [7:0] tx_byte_a, tx_byte_b, tx_byte_c;
  logic [0:0] mem_region_a, mem_region_b, mem_region_c;
  logic [7:0] mem_addr_a, mem_addr_b, mem_addr_c;
  logic mem_we_a, mem_we_b, mem_we_c;
  logic [31:0] mem_wdata_a, mem_wdata_b, mem_wdata_c;
  logic [31:0] rdata_zero, rdata_c;
  logic [1:0] done_a, done_b, done_c;
  logic busy_a, busy_b, busy_c;
  logic [7:0] checksum_a, checksum_b, checksum_c;

  int total = 0;
  int bad = 0;
  wr_t qa[$];
  wr_t qb[$];
  logic [7:0] txq[$];

  logic [31:0] ram [2];
  logic pend;
  logic [3:0] act_cnt;

  uart_word_bridge #(.WORD_BYTES(4), .ADDR_W(8), .N_REGIONS(2), .DEPTH(4),
    .LITTLE_ENDIAN(1'b1), .RD_LATENCY(1), .GAP_CLKS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode), .region(region),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_ready(tx_ready),
    .tx_valid(tx_valid_a), .tx_byte(tx_byte_a), .mem_region(mem_region_a),
    .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(rdata_zero), .done(done_a), .busy(busy_a), .checksum(checksum_a));

  uart_word_bridge #(.WORD_BYTES(4), .ADDR_W(8), .N_REGIONS(2), .DEPTH(256),
    .LITTLE_ENDIAN(1'b0), .RD_LATENCY(1), .GAP_CLKS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode), .region(region),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_ready(tx_ready),
    .tx_valid(tx_valid_b), .tx_byte(tx_byte_b), .mem_region(mem_region_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(rdata_zero), .done(done_b), .busy(busy_b), .checksum(checksum_b));

  uart_word_bridge #(.WORD_BYTES(4), .ADDR_W(8), .N_REGIONS(2), .DEPTH(2),
    .LITTLE_ENDIAN(1'b1), .RD_LATENCY(1), .GAP_CLKS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .mode(mode), .region(region),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_ready(tx_ready),
    .tx_valid(tx_valid_c), .tx_byte(tx_byte_c), .mem_region(mem_region_c),
    .mem_addr(mem_addr_c), .mem_we(mem_we_c), .mem_wdata(mem_wdata_c),
    .mem_rdata(rdata_c), .done(done_c), .busy(busy_c), .checksum(checksum_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdata_zero = 32'h0;

  // Synchronous-read RAM, one clock of latency.
  always @(posedge clk) rdata_c <= ram[mem_addr_c[0]];

  // UART_Tx model: Active rises one clock after the start strobe, stays 6 clocks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      act_cnt <= 4'd0;
    end else begin
      pend <= tx_valid_c;
      if (pend) act_cnt <= 4'd6;
      else if (act_cnt != 4'd0) act_cnt <= act_cnt - 4'd1;
    end
  end
  assign tx_ready = (act_cnt == 4'd0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got event %0h expected none", name, act);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t e;
    logic [7:0] b;
    if (mem_we_a) begin
      if (qa.size() == 0) unexpected("a_we", {24'h0, mem_addr_a, mem_wdata_a});
      else begin
        e = qa.pop_front();
        check("a_we_region", mem_region_a, e.region);
        check("a_we_addr", mem_addr_a, e.addr);
        check("a_we_data", mem_wdata_a, e.data);
      end
    end
    if (mem_we_b) begin
      if (qb.size() == 0) unexpected("b_we", {24'h0, mem_addr_b, mem_wdata_b});
      else begin
        e = qb.pop_front();
        check("b_we_region", mem_region_b, e.region);
        check("b_we_addr", mem_addr_b, e.addr);
        check("b_we_data", mem_wdata_b, e.data);
      end
    end
    if (mem_we_c) unexpected("c_we", {24'h0, mem_addr_c, mem_wdata_c});
    if (tx_valid_a) unexpected("a_tx", tx_byte_a);
    if (tx_valid_b) unexpected("b_tx", tx_byte_b);
    if (tx_valid_c) begin
      check("c_tx_ready", tx_ready, 1'b1);
      if (txq.size() == 0) unexpected("c_tx", tx_byte_c);
      else begin
        b = txq.pop_front();
        check("c_tx_byte", tx_byte_c, b);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic push_a(input logic [0:0] r, input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.region = r; e.addr = a; e.data = d;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [0:0] r, input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.region = r; e.addr = a; e.data = d;
    qb.push_back(e);
  endtask

  task automatic push_dump();
    logic [7:0] seq [8];
    seq = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int i = 0; i < 8; i++) txq.push_back(seq[i]);
  endtask

  initial begin
    logic [31:0] w3 [4];
    int k;
    ram[0] = 32'h11223344;
    ram[1] = 32'hAABBCCDD;
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    mode = 1'b0; region = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    check("rst_done_a", done_a, 2'b00);
    check("rst_checksum_a", checksum_a, 8'h00);
    check("rst_busy_a", busy_a, 1'b0);

    // Load, little endian, region 0.
    en_a = 1'b1;
    cycles(2);
    push_a(1'b0, 8'd0, 32'h12345678);
    send_byte(8'h78);
    send_byte(8'h56);
    check("t1_busy_partial", busy_a, 1'b1);
    send_byte(8'h34);
    send_byte(8'h12);
    cycles(2);
    check("t1_checksum", checksum_a, 8'h14);
    check("t1_busy_after", busy_a, 1'b0);

    // Region 1 on DEPTH=4: four writes, then done blocks further bytes.
    region = 1'b1;
    cycles(3);
    check("t3_abort_checksum", checksum_a, 8'h00);
    w3 = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    for (int j = 0; j < 4; j++) push_a(1'b1, 8'(j), w3[j]);
    k = 1;
    for (int j = 0; j < 12; j++) begin send_byte(8'(k)); k++; end
    check("t3_done_early", done_a, 2'b00);
    for (int j = 0; j < 4; j++) begin send_byte(8'(k)); k++; end
    cycles(1);
    check("t3_done", done_a, 2'b10);
    check("t3_checksum16", checksum_a, 8'h88);
    for (int j = 0; j < 4; j++) begin send_byte(8'(k)); k++; end
    cycles(2);
    check("t3_checksum_held", checksum_a, 8'h88);
    check("t3_queue_a", qa.size(), 0);

    // Big-endian instance, two words.
    en_a = 1'b0; region = 1'b0; en_b = 1'b1;
    cycles(2);
    push_b(1'b0, 8'd0, 32'h78563412);
    push_b(1'b0, 8'd1, 32'h9ABCDEF0);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
    cycles(2);
    check("t2_checksum", checksum_b, 8'h38);
    check("t2_queue_b", qb.size(), 0);

    // Partial word discarded by a mode toggle.
    en_b = 1'b0; en_a = 1'b1;
    cycles(2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("t5_busy_partial", busy_a, 1'b1);
    mode = 1'b1;
    cycles(1);
    mode = 1'b0;
    cycles(3);
    check("t5_busy_cleared", busy_a, 1'b0);
    check("t5_checksum_cleared", checksum_a, 8'h00);
    push_a(1'b0, 8'd0, 32'hC4C3C2C1);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    cycles(2);
    check("t5_checksum", checksum_a, 8'h0A);
    check("t5_queue_a", qa.size(), 0);

    // Dump of a two-word region through the transmitter model.
    en_a = 1'b0;
    push_dump();
    mode = 1'b1; en_c = 1'b1;
    for (int i = 0; i < 400 && !done_c[0]; i++) @(negedge clk);
    check("t4_done", done_c, 2'b01);
    check("t4_checksum", checksum_c, 8'hB8);
    check("t4_busy_fin", busy_c, 1'b0);
    check("t4_queue_tx", txq.size(), 0);

    // Restart the dump and reset it asynchronously mid-stream.
    mode = 1'b0;
    cycles(3);
    push_dump();
    mode = 1'b1;
    for (int i = 0; i < 200 && !(tx_valid_c && checksum_c == 8'h44); i++) @(negedge clk);
    check("t6_reached_mid", {tx_valid_c, checksum_c}, {1'b1, 8'h44});
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_tx_valid", tx_valid_c, 1'b0);
    check("t6_mem_we", mem_we_c, 1'b0);
    check("t6_done", done_c, 2'b00);
    check("t6_checksum", checksum_c, 8'h00);
    check("t6_busy", busy_c, 1'b0);
    txq.delete();
    cycles(2);
    rst_n = 1'b1;
    en_c = 1'b0;
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
